// File: rtl/puf_eval_ctrl.sv
// ============================================================================
// Module     : puf_eval_ctrl
// Description: Sequencing controller for the 8-lane arbiter-PUF array.
//              Accepts a challenge (valid/ready), drives it to the array,
//              produces a clean low->high evaluation pulse, samples the
//              response and returns it (valid/ready). With voting compiled
//              in, the evaluation repeats NUM_EVAL times and the result is a
//              per-lane majority plus an instability flag.
// Build macro: PUF_MAJORITY_VOTE_EN -- defined: NUM_EVAL evaluations with
//              majority vote and live rsp_unstable; undefined: exactly one
//              evaluation, rsp_unstable tied low, no vote counters.
// Ports      :
//   clk, rst_n       clock / asynchronous active-low reset
//   req_valid/ready  challenge handshake, req_challenge[CH_W]
//   puf_challenge    registered challenge to the array
//   puf_pulse        registered evaluation pulse to the array
//   puf_resp         raw lane responses [RESP_W]
//   rsp_valid/ready  result handshake, rsp_data[RESP_W], rsp_unstable
//   busy             high whenever the controller is not idle
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_eval_ctrl #(
    parameter int CH_W       = 8,
    parameter int RESP_W     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int NUM_EVAL   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CH_W-1:0]   req_challenge,
    output logic [CH_W-1:0]   puf_challenge,
    output logic              puf_pulse,
    input  logic [RESP_W-1:0] puf_resp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RESP_W-1:0] rsp_data,
    output logic              rsp_unstable,
    output logic              busy
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int EVALS = NUM_EVAL;
`else
    // NUM_EVAL has no effect without voting: a single evaluation runs.
    localparam int EVALS = (NUM_EVAL > 0) ? 1 : 1;
`endif

    // Settle counter runs 0..SETTLE_CYC-1 in LOW and in HIGH.
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int EW = $clog2(EVALS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOW    = 3'd1,
        ST_HIGH   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SW-1:0]     r_settle;
    logic [SW-1:0]     w_settle_nxt;
    logic [EW-1:0]     r_evals;
    logic [EW-1:0]     w_evals_nxt;
    logic              r_alive;
    logic              r_pulse;
    logic              r_rsp_valid;
    logic              r_rsp_unstable;
    logic [CH_W-1:0]   r_challenge;
    logic [RESP_W-1:0] r_rsp_data;
    logic              w_accept;
    logic              w_rsp_fire;
    logic              w_settled;
    logic              w_finalize;
    logic [RESP_W-1:0] w_result;
    logic              w_unstable;

    // req_ready must stay low through reset, so it is qualified by a flag
    // that only sets on the first clock edge after reset release.
    assign req_ready     = (r_state == ST_IDLE) && r_alive;
    assign busy          = (r_state != ST_IDLE);
    assign puf_challenge = r_challenge;
    assign puf_pulse     = r_pulse;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_unstable  = r_rsp_unstable;

    assign w_accept   = req_valid && req_ready;
    assign w_rsp_fire = r_rsp_valid && rsp_ready;
    assign w_settled  = (r_settle == SW'(SETTLE_CYC - 1));
    // First DONE cycle folds the accumulated evaluations into the result.
    assign w_finalize = (r_state == ST_DONE) && !r_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_settle <= '0;
            r_evals <= '0;
            r_alive <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_settle <= w_settle_nxt;
            r_evals <= w_evals_nxt;
            r_alive <= 1'b1;
            // Pulse is a flop decoded from the next state: glitch-free and
            // aligned with the state it belongs to.
            r_pulse <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_SAMPLE);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_evals_nxt  = r_evals;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = ST_LOW;
                    w_settle_nxt = '0;
                    w_evals_nxt  = '0;
                end
            end
            ST_LOW: begin
                if (w_settled) begin
                    w_state_nxt  = ST_HIGH;
                    w_settle_nxt = '0;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_settled) begin
                    w_state_nxt  = ST_SAMPLE;
                    w_settle_nxt = '0;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end
            ST_SAMPLE: begin
                w_evals_nxt = r_evals + 1'b1;
                w_state_nxt = (r_evals == EW'(EVALS - 1)) ? ST_DONE : ST_LOW;
            end
            ST_DONE: begin
                if (w_rsp_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_challenge    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_unstable <= 1'b0;
        end else begin
            if (w_accept) begin
                r_challenge <= req_challenge;
            end
            if (w_finalize) begin
                r_rsp_valid    <= 1'b1;
                r_rsp_data     <= w_result;
                r_rsp_unstable <= w_unstable;
            end else if (w_rsp_fire) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int CW = $clog2(NUM_EVAL + 1);

    // Per-lane count of '1' samples; sized so NUM_EVAL ones cannot wrap.
    logic [CW-1:0] r_cnt [RESP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < RESP_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_state == ST_SAMPLE) begin
            for (int i = 0; i < RESP_W; i++) begin
                r_cnt[i] <= r_cnt[i] + CW'(puf_resp[i]);
            end
        end
    end

    always_comb begin
        w_result   = '0;
        w_unstable = 1'b0;
        for (int i = 0; i < RESP_W; i++) begin
            w_result[i] = (r_cnt[i] > CW'(NUM_EVAL / 2));
            if ((r_cnt[i] != '0) && (r_cnt[i] != CW'(NUM_EVAL))) begin
                w_unstable = 1'b1;
            end
        end
    end
`else
    logic [RESP_W-1:0] r_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
        end else if (r_state == ST_SAMPLE) begin
            r_sample <= puf_resp;
        end
    end

    assign w_result   = r_sample;
    assign w_unstable = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_puf_eval_ctrl.sv
// ============================================================================
// Module     : tb_puf_eval_ctrl
// Description: Self-checking bench for puf_eval_ctrl. A behavioural PUF model
//              returns one tabled response per evaluation pulse; the expected
//              result is the per-lane majority of that table.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_puf_eval_ctrl;

    localparam int CH_W   = 8;
    localparam int RESP_W = 8;
    localparam int S      = 4;
    localparam int NE     = 5;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int EVALS = NE;
`else
    localparam int EVALS = 1;
`endif
    localparam int LAT = EVALS * (2 * S + 1) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [CH_W-1:0]   req_challenge;
    logic [CH_W-1:0]   puf_challenge;
    logic              puf_pulse;
    logic [RESP_W-1:0] puf_resp;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RESP_W-1:0] rsp_data;
    logic              rsp_unstable;
    logic              busy;

    int n_err = 0;
    int n_chk = 0;
    logic [7:0] resp_tab [16];

    puf_eval_ctrl #(
        .CH_W(CH_W), .RESP_W(RESP_W), .SETTLE_CYC(S), .NUM_EVAL(NE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
        .puf_challenge(puf_challenge), .puf_pulse(puf_pulse), .puf_resp(puf_resp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_unstable(rsp_unstable), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: majority of the first EVALS table entries, lane by lane.
    function automatic logic [8:0] ref_result();
        logic [7:0] d;
        logic       u;
        int         ones;
        d = '0;
        u = 1'b0;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int k = 0; k < EVALS; k++) ones += int'(resp_tab[k][b]);
            d[b] = (2 * ones > EVALS);
            if (ones != 0 && ones != EVALS) u = 1'b1;
        end
        return {u, d};
    endfunction

    // Offer a challenge, follow the pulse train until rsp_valid, check all.
    task automatic run_req(input logic [7:0] ch);
        int         edge_n;
        int         pulses;
        int         low_run;
        logic       prev;
        logic       done;
        logic       chal_bad;
        logic [8:0] exp;
        exp = ref_result();
        req_challenge = ch;
        req_valid = 1'b1;
        puf_resp = resp_tab[0];
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_challenge = 8'($urandom);
        check("chal_latch", {24'd0, puf_challenge}, {24'd0, ch});
        check("busy_run", {31'd0, busy}, 32'd1);
        edge_n = 0;
        pulses = 0;
        low_run = puf_pulse ? 0 : 1;
        prev = puf_pulse;
        done = 1'b0;
        chal_bad = 1'b0;
        while (!done && edge_n < 400) begin
            @(posedge clk); #1;
            edge_n++;
            if (puf_challenge !== ch) chal_bad = 1'b1;
            if (puf_pulse && !prev) begin
                pulses++;
                check("low_before_rise", low_run, S);
            end
            if (!puf_pulse) low_run = prev ? 1 : low_run + 1;
            prev = puf_pulse;
            if (pulses > 0) puf_resp = resp_tab[(pulses - 1) % 16];
            if (rsp_valid === 1'b1) done = 1'b1;
        end
        check("latency", edge_n, LAT);
        check("pulse_count", pulses, EVALS);
        check("chal_hold", {31'd0, chal_bad}, 32'd0);
        check("rsp_data", {24'd0, rsp_data}, {24'd0, exp[7:0]});
        check("rsp_unstable", {31'd0, rsp_unstable}, {31'd0, exp[8]});
        check("req_ready_done", {31'd0, req_ready}, 32'd0);
        check("pulse_done", {31'd0, puf_pulse}, 32'd0);
    endtask

    // Hold the result for 'hold' cycles (with an ignored offer), then accept.
    // With b2b the next challenge is already offered on the accept edge.
    task automatic finish_rsp(input int hold, input bit b2b, input logic [7:0] nxt);
        logic [7:0] d0;
        logic [7:0] c0;
        logic       u0;
        logic       bad;
        d0 = rsp_data;
        u0 = rsp_unstable;
        c0 = puf_challenge;
        bad = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i == hold / 2);
            req_challenge = 8'hFF;
            @(posedge clk); #1;
            if (rsp_data !== d0 || rsp_unstable !== u0 || rsp_valid !== 1'b1 ||
                req_ready !== 1'b0 || busy !== 1'b1)
                bad = 1'b1;
        end
        req_valid = 1'b0;
        check("hold_stable", {31'd0, bad}, 32'd0);
        check("chal_ignored", {24'd0, puf_challenge}, {24'd0, c0});
        rsp_ready = 1'b1;
        if (b2b) begin
            req_valid = 1'b1;
            req_challenge = nxt;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        check("idle_after_rsp", {31'd0, busy}, 32'd0);
        check("no_accept_on_rsp_edge", {24'd0, puf_challenge}, {24'd0, c0});
    endtask

    task automatic fill_random();
        logic [7:0] base;
        base = 8'($urandom);
        for (int k = 0; k < 16; k++)
            resp_tab[k] = base ^ ((($urandom % 3) == 0) ? 8'($urandom & $urandom) : 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;
        bit         b2b;
        int         waited;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_challenge = '0;
        rsp_ready = 1'b0;
        puf_resp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_outputs", {puf_challenge, puf_pulse, rsp_valid, rsp_data, rsp_unstable, busy},
              32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("req_ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Steady response, then backpressure and back-to-back into 8'h12.
        for (int k = 0; k < 16; k++) resp_tab[k] = 8'h3C;
        run_req(8'hA5);
        finish_rsp(20, 1'b1, 8'h12);
        resp_tab[0] = 8'h81; resp_tab[1] = 8'h80; resp_tab[2] = 8'h81;
        resp_tab[3] = 8'h81; resp_tab[4] = 8'h80;
        run_req(8'h12);
        finish_rsp(2, 1'b0, 8'h00);

        // Randomized requests.
        cur = 8'($urandom);
        fill_random();
        for (int n = 0; n < 20; n++) begin
            run_req(cur);
            nxt = 8'($urandom);
            b2b = ($urandom % 2) == 1;
            finish_rsp(int'($urandom_range(0, 6)), b2b, nxt);
            fill_random();
            if (!b2b) repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            cur = nxt;
        end

        // Reset in the middle of the HIGH phase.
        #1;
        req_valid = 1'b1;
        req_challenge = 8'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waited = 0;
        while (puf_pulse !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reached_high", {31'd0, puf_pulse}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_pulse", {31'd0, puf_pulse}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);
        check("post_rst_chal", {24'd0, puf_challenge}, 32'd0);
        waited = 0;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) waited++;
        end
        check("no_stale_result", waited, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
